// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared types, constants and helpers for the keypad scanner
// Purpose: scan FSM state type, column strobe constants, the 5-bit candidate
//   encoding (MSB set = no key) and the snapshot-to-candidate decoder.
// Ports: none (package).
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_DRIVE  = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_EVAL   = 2'd2
  } scan_state_e;

  localparam logic [3:0] COL_INIT = 4'b1110;
  // No column is driven during EVAL, so the rotation shows a one-cycle gap.
  localparam logic [3:0] COL_IDLE = 4'b1111;
  localparam logic [4:0] KEY_NONE = 5'b10000;
  localparam int CODE_ROW_LSB = 2;
  localparam int CODE_COL_LSB = 0;

  function automatic logic [3:0] col_strobe(input logic [1:0] idx);
    col_strobe = ~(4'b0001 << idx);
  endfunction

  // Snapshot bit col*4+row holds "row pressed while col driven". Exactly one
  // bit yields that key's code; zero or several bits (ghosting) yield KEY_NONE.
  function automatic logic [4:0] key_candidate(input logic [15:0] snap);
    logic [4:0] cand;
    int hits;
    cand = KEY_NONE;
    hits = 0;
    for (int b = 0; b < 16; b++) begin
      if (snap[b]) begin
        hits = hits + 1;
        cand = 5'b00000;
        cand[CODE_ROW_LSB +: 2] = b[1:0];
        cand[CODE_COL_LSB +: 2] = b[3:2];
      end
    end
    if (hits != 1) cand = KEY_NONE;
    return cand;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key report handshake between scanner and operand-entry logic
// Purpose: groups the key report outputs and the consumer acknowledge.
// Ports (master = scanner): key_code, key_valid, key_held, key_overrun out; key_ack in.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       key_overrun;

  modport master (
    output key_code, key_valid, key_held, key_overrun,
    input  key_ack
  );

  modport slave (
    input  key_code, key_valid, key_held, key_overrun,
    output key_ack
  );
endinterface

// File: rtl/keypad_scanner_debounce.sv
// rtl/keypad_scanner_debounce.sv - per-scan candidate debounce with optional auto-repeat
// Purpose: decodes the full-scan snapshot, counts consecutive identical scans,
//   and emits accept / release / repeat strobes during the EVAL cycle.
//   Auto-repeat exists only when KEYPAD_REPEAT_EN is defined.
// Ports: clkd, rst (async, active-high); eval, snapshot[15:0] in;
//   accept, key_release, key_repeat, acc_code[3:0] out (combinational, valid in EVAL).
module keypad_scanner_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 8
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_SCANS = 64
`endif
) (
  input  logic        clkd,
  input  logic        rst,
  input  logic        eval,
  input  logic [15:0] snapshot,
  output logic        accept,
  output logic        key_release,
  output logic        key_repeat,
  output logic [3:0]  acc_code
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [4:0]    candidate;
  logic [4:0]    last_candidate;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] next_cnt;
  logic          reported;
  logic [3:0]    reported_code;
  logic          stable;
  logic          same_key;

  assign candidate = key_candidate(snapshot);

  always_comb begin
    next_cnt = CW'(1);
    if (candidate == last_candidate)
      next_cnt = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
  end

  assign stable = (next_cnt == CNT_MAX);
  // Tying "reported" to a code lets a different stable key count as a new
  // press, while a bounce back to the same key is not re-reported.
  assign same_key    = reported && (candidate == {1'b0, reported_code});
  assign accept      = eval && stable && !candidate[4] && !same_key;
  assign key_release = eval && stable && candidate[4];
  assign acc_code    = candidate[3:0];

  always_ff @(posedge clkd or posedge rst) begin
    if (rst) begin
      last_candidate <= KEY_NONE;
      stable_cnt     <= '0;
      reported       <= 1'b0;
      reported_code  <= 4'h0;
    end else if (eval) begin
      last_candidate <= candidate;
      stable_cnt     <= next_cnt;
      if (accept) begin
        reported      <= 1'b1;
        reported_code <= candidate[3:0];
      end else if (key_release) begin
        reported <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);

  logic [RW-1:0] rep_cnt;
  logic          held_stable;

  assign held_stable = stable && same_key;
  assign key_repeat  = eval && held_stable && (rep_cnt == REP_LAST);

  always_ff @(posedge clkd or posedge rst) begin
    if (rst)
      rep_cnt <= '0;
    else if (eval)
      rep_cnt <= (held_stable && rep_cnt != REP_LAST) ? rep_cnt + 1'b1 : '0;
  end
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and key handshake
// Purpose: rotates one-cold column strobes, synchronizes and samples the rows,
//   debounces full scans and reports one key code per press.
//   Optional auto-repeat: define KEYPAD_REPEAT_EN.
// Ports: clkd, rst (async, active-high); col_n[3:0] out; row_n[3:0] in;
//   key_if (master): key_code, key_valid, key_held, key_overrun out, key_ack in.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 8
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_SCANS = 64
`endif
) (
  input  logic                   clkd,
  input  logic                   rst,
  output logic [3:0]             col_n,
  input  logic [3:0]             row_n,
  keypad_scanner_if.master       key_if
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  scan_state_e state;
  logic [SW-1:0] settle_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    col_next;
  logic [15:0]   snapshot;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic          eval;
  logic          accept;
  logic          key_release;
  logic          key_repeat;
  logic [3:0]    acc_code;

  assign col_next = col_idx + 2'd1;
  assign eval     = (state == ST_EVAL);

  // Rows idle high, so the synchronizer resets to "nothing pressed".
  always_ff @(posedge clkd or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clkd or posedge rst) begin
    if (rst) begin
      state      <= ST_DRIVE;
      settle_cnt <= '0;
      col_idx    <= 2'd0;
      col_n      <= COL_INIT;
      snapshot   <= 16'h0000;
    end else begin
      case (state)
        ST_DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          snapshot[{col_idx, 2'b00} +: 4] <= ~row_sync;
          col_idx <= col_next;
          if (col_idx == 2'd3) begin
            state <= ST_EVAL;
            col_n <= COL_IDLE;
          end else begin
            state <= ST_DRIVE;
            col_n <= col_strobe(col_next);
          end
        end
        ST_EVAL: begin
          state <= ST_DRIVE;
          col_n <= COL_INIT;
        end
        default: begin
          state <= ST_DRIVE;
          col_n <= COL_INIT;
        end
      endcase
    end
  end

  keypad_scanner_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_SCANS(REPEAT_SCANS)
`endif
  ) u_debounce (
    .clkd        (clkd),
    .rst         (rst),
    .eval        (eval),
    .snapshot    (snapshot),
    .accept      (accept),
    .key_release (key_release),
    .key_repeat  (key_repeat),
    .acc_code    (acc_code)
  );

  // An ack on the same edge frees the slot, so a coincident new key loads
  // instead of counting as an overrun. Dropped repeats never flag overrun.
  always_ff @(posedge clkd or posedge rst) begin
    if (rst) begin
      key_if.key_code    <= 4'h0;
      key_if.key_valid   <= 1'b0;
      key_if.key_held    <= 1'b0;
      key_if.key_overrun <= 1'b0;
    end else begin
      if (key_if.key_ack)
        key_if.key_valid <= 1'b0;
      if (accept || key_repeat) begin
        if (!key_if.key_valid || key_if.key_ack) begin
          key_if.key_code  <= acc_code;
          key_if.key_valid <= 1'b1;
        end else if (accept) begin
          key_if.key_overrun <= 1'b1;
        end
      end
      if (accept)
        key_if.key_held <= 1'b1;
      else if (key_release)
        key_if.key_held <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 2;
  localparam int REP    = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic        clkd = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] keys = 16'h0000;
  logic [6:0]  outs;

  int checks = 0;
  int errors = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_SCANS(REP)
`endif
  ) dut (
    .clkd  (clkd),
    .rst   (rst),
    .col_n (col_n),
    .row_n (row_n),
    .key_if(kif)
  );

  always #5 clkd = ~clkd;

  assign outs = {kif.key_valid, kif.key_code, kif.key_held, kif.key_overrun};

  // Keypad matrix: key (r,c) is bit r*4+c; a pressed key shorts row r to column c.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] k;
    bit          ack_mid;
    bit          ack_eval;
    logic [6:0]  exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] key_bit(input int r, input int c);
    return 16'h0001 << (r*4 + c);
  endfunction

  function automatic logic [6:0] pack(input bit v, input logic [3:0] code, input bit h, input bit o);
    return {v, code, h, o};
  endfunction

  function automatic void add(input logic [15:0] k, input bit am, input bit ae,
                              input bit v, input logic [3:0] code, input bit h, input bit o);
    vec_t t;
    t.k = k; t.ack_mid = am; t.ack_eval = ae; t.exp = pack(v, code, h, o);
    tbl.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clkd);
    rst = 1'b1;
    kif.key_ack = 1'b0;
    repeat (3) @(negedge clkd);
    rst = 1'b0;
  endtask

  // Waits for the EVAL cycle, optionally acks on its edge, returns just after it.
  task automatic wait_eval(input bit ack_eval);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkd);
      if (col_n == 4'b1111) begin
        found = 1'b1;
        break;
      end
    end
    check("eval_seen", 32'(found), 32'd1);
    kif.key_ack = ack_eval;
    @(posedge clkd);
    #1;
    kif.key_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clkd);
    kif.key_ack = 1'b1;
    @(posedge clkd);
    #1;
    kif.key_ack = 1'b0;
    check("ack_clears_valid", 32'(kif.key_valid), 32'd0);
  endtask

  // Scan-level reference: a key is stable once the last DEB scan candidates agree.
  logic [4:0] hist[$];
  bit         m_rep, m_valid, m_held, m_over;
  logic [3:0] m_rep_code, m_code;
  int         m_held_cnt;

  function automatic void model_reset();
    hist.delete();
    m_rep = 0; m_valid = 0; m_held = 0; m_over = 0;
    m_rep_code = 4'h0; m_code = 4'h0; m_held_cnt = 0;
  endfunction

  function automatic void model_scan(input logic [15:0] k, input bit ack_eval);
    logic [4:0] cand;
    int run;
    bit stable, acc, rpt;
    cand = 5'h10;
    if ($countones(k) == 1)
      for (int i = 0; i < 16; i++) if (k[i]) cand = {1'b0, 4'(i)};
    hist.push_back(cand);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != cand) break;
      run++;
    end
    stable = (run >= DEB);
    acc = 0;
    rpt = 0;
    if (stable && !cand[4] && !(m_rep && cand[3:0] == m_rep_code)) begin
      acc = 1; m_rep = 1; m_rep_code = cand[3:0]; m_held_cnt = 0;
    end else if (stable && m_rep && !cand[4] && cand[3:0] == m_rep_code) begin
      m_held_cnt++;
      rpt = REPEAT_ON && (m_held_cnt % REP == 0);
    end else begin
      m_held_cnt = 0;
    end
    if (stable && cand[4]) begin
      m_rep = 0; m_held = 0;
    end
    if (ack_eval) m_valid = 0;
    if (acc) m_held = 1;
    if (acc || rpt) begin
      if (!m_valid) begin
        m_valid = 1; m_code = cand[3:0];
      end else if (acc) begin
        m_over = 1;
      end
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_col;
    logic [15:0] nk;
    bit am, ae;
    int p, a, b;

    kif.key_ack = 1'b0;

    // Directed vectors, one row per scan: keys held during the scan, acks, outputs after EVAL.
    for (int i = 0; i < 3; i++) add(key_bit(2,1), 0, 0, i > 0, (i > 0) ? 4'h9 : 4'h0, i > 0, 0);
    add(key_bit(2,1), 1, 0, 0, 4'h9, 1, 0);
    add(16'h0, 0, 0, 0, 4'h9, 1, 0);
    add(16'h0, 0, 0, 0, 4'h9, 0, 0);
    for (int i = 0; i < 20; i++) add((i % 2 == 0) ? key_bit(0,3) : 16'h0, i == 5, 0, 0, 4'h9, 0, 0);
    for (int i = 0; i < 6; i++) add(key_bit(0,0) | key_bit(1,2), 0, 0, 0, 4'h9, 0, 0);
    add(key_bit(3,0), 0, 0, 0, 4'h9, 0, 0);
    add(key_bit(3,0), 0, 0, 1, 4'hC, 1, 0);
    add(16'h0, 0, 0, 1, 4'hC, 1, 0);
    add(16'h0, 0, 0, 1, 4'hC, 0, 0);
    add(key_bit(0,1), 0, 0, 1, 4'hC, 0, 0);
    add(key_bit(0,1), 0, 1, 1, 4'h1, 1, 0);
    add(16'h0, 1, 0, 0, 4'h1, 1, 0);
    add(16'h0, 0, 0, 0, 4'h1, 0, 0);
    add(key_bit(3,3), 0, 0, 0, 4'h1, 0, 0);
    add(key_bit(3,3), 0, 0, 1, 4'hF, 1, 0);
    add(16'h0, 0, 0, 1, 4'hF, 1, 0);
    add(16'h0, 0, 0, 1, 4'hF, 0, 0);
    add(key_bit(1,0), 0, 0, 1, 4'hF, 0, 0);
    add(key_bit(1,0), 0, 0, 1, 4'hF, 1, 1);
    add(key_bit(1,0), 1, 0, 0, 4'hF, 1, 1);
    add(16'h0, 0, 0, 0, 4'hF, 1, 1);
    add(16'h0, 0, 0, 0, 4'hF, 0, 1);

    // Reset state and column rotation with no keys.
    repeat (2) @(negedge clkd);
    check("reset_col_n", 32'(col_n), 32'hE);
    check("reset_outputs", 32'(outs), 32'h0);
    rst = 1'b0;
    for (int t = 0; t < 42; t++) begin
      p = t % 21;
      exp_col = (p == 20) ? 4'b1111 : ~(4'b0001 << (p / 5));
      check("col_rotation", 32'(col_n), 32'(exp_col));
      @(negedge clkd);
    end
    check("idle_outputs", 32'(outs), 32'h0);

    // Table-driven directed scans.
    do_reset();
    foreach (tbl[i]) begin
      keys = tbl[i].k;
      if (tbl[i].ack_mid) pulse_ack();
      wait_eval(tbl[i].ack_eval);
      check($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
    end

    // Reset asserted mid-scan while r1c1 is reported and held.
    keys = key_bit(1,1);
    wait_eval(0);
    wait_eval(0);
    check("r1c1_reported", 32'(outs), 32'(pack(1, 4'h5, 1, 1)));
    a = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkd);
      if (col_n == 4'b1011) begin
        a = 1;
        break;
      end
    end
    check("reached_col2", 32'(a), 32'd1);
    @(posedge clkd);
    #2;
    rst = 1'b1;
    #1;
    check("midscan_rst_col_n", 32'(col_n), 32'hE);
    check("midscan_rst_outputs", 32'(outs), 32'h0);
    @(negedge clkd);
    rst = 1'b0;
    wait_eval(0);
    check("after_rst_scan1", 32'(outs), 32'(pack(0, 4'h0, 0, 0)));
    wait_eval(0);
    check("after_rst_scan2", 32'(outs), 32'(pack(1, 4'h5, 1, 0)));
    for (int j = 1; j <= 8; j++) begin
      pulse_ack();
      wait_eval(0);
      check($sformatf("repeat_scan%0d", j), 32'(outs),
            32'(pack(REPEAT_ON && (j % REP == 0), 4'h5, 1, 0)));
    end

    // Randomized scans against the scan-level reference.
    keys = 16'h0;
    do_reset();
    model_reset();
    for (int s = 0; s < 150; s++) begin
      p = $urandom_range(0, 99);
      nk = keys;
      if (p >= 55 && p < 70) begin
        nk = 16'h0;
      end else if (p >= 70 && p < 93) begin
        nk = key_bit($urandom_range(0, 3), $urandom_range(0, 3));
      end else if (p >= 93) begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        nk = (16'h0001 << a) | (16'h0001 << b);
      end
      am = ($urandom_range(0, 99) < 20);
      ae = ($urandom_range(0, 99) < 15);
      keys = nk;
      if (am) begin
        pulse_ack();
        m_valid = 0;
      end
      wait_eval(ae);
      model_scan(nk, ae);
      check($sformatf("rand%0d", s), 32'(outs), 32'(pack(m_valid, m_code, m_held, m_over)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
